// File: rtl/op_dispatcher.sv
// Instruction-driven dispatcher: fetches 16-bit words from a synchronous ROM,
// issues one-cycle engine commands and waits for a completion interrupt,
// with a per-op watchdog that parks the sequencer in ERR on expiry.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | rom_addr presented; ROM samples it at the end of this cycle
// DECODE | rom_data valid; classify NOP / END / engine command
// ISSUE  | command output is nonzero for exactly this cycle
// WAIT   | waiting for interrupt; watchdog timer counting
// DONE   | END reached; done pulses on the following cycle
// ERR    | watchdog expired; error held until the next start
module op_dispatcher #(
    parameter logic [9:0] TIMEOUT = 10'd1023,
    parameter int         PC_W    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] prog_base,
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_data,
    output logic [3:0]      command,
    output logic [2:0]      start_addr,
    input  logic            interrupt,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [PC_W-1:0] err_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0]      OP_NOP = 4'h0;
    localparam logic [3:0]      OP_END = 4'hF;
    localparam logic [PC_W-1:0] PC_ONE = 1;
    localparam logic [9:0]      TMR_ONE = 10'd1;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [2:0]      saddr_q, saddr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [PC_W-1:0] err_pc_q, err_pc_d;
    logic [9:0]      timer_q, timer_d;
    logic [9:0]      timer_inc;
    logic [3:0]      opcode;

    // Low nine instruction bits are reserved and deliberately ignored.
    logic            rsvd_unused;
    assign rsvd_unused = ^rom_data[8:0];

    assign opcode    = rom_data[15:12];
    assign timer_inc = timer_q + TMR_ONE;

    // Sequencer state register and all registered outputs; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cmd_q    <= 4'h0;
            saddr_q  <= 3'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            err_pc_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cmd_q    <= cmd_d;
            saddr_q  <= saddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            err_pc_q <= err_pc_d;
            timer_q  <= timer_d;
        end
    end

    // Next-state and next-output logic; command and done default low so they pulse.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cmd_d    = 4'h0;
        saddr_d  = saddr_q;
        done_d   = 1'b0;
        error_d  = error_q;
        err_pc_d = err_pc_q;
        timer_d  = timer_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    pc_d    = prog_base;
                    error_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_END) begin
                    state_d = S_DONE;
                end else if (opcode == OP_NOP) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end else begin
                    cmd_d   = opcode;
                    saddr_d = rom_data[11:9];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the expiry cycle still counts as success.
                if (interrupt) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TIMEOUT) begin
                        err_pc_d = pc_q;
                        error_d  = 1'b1;
                        state_d  = S_ERR;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy drops on the same edge that raises done.
        busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_ISSUE) ||
                 (state_d == S_WAIT)  || (state_d == S_DONE);
    end

    assign rom_addr   = pc_q;
    assign command    = cmd_q;
    assign start_addr = saddr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_pc     = err_pc_q;

endmodule
